// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bus into the hazard scoreboard, plus the stall request it returns.
interface hazard_scoreboard_if;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic       id_ignore_hazard;
  logic       id_wb_en;
  logic       id_mem_read;
  logic [3:0] id_dest;
  logic       hazard;

  modport master (
    output id_src1, id_src2, id_two_src, id_ignore_hazard,
           id_wb_en, id_mem_read, id_dest,
    input  hazard
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, id_ignore_hazard,
           id_wb_en, id_mem_read, id_dest,
    output hazard
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadows the EXE/MEM destination state and raises a combinational stall request
// when the ID instruction depends on an in-flight result it cannot yet consume.
module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               forward_en,
  input  logic               freeze,
  input  logic               flush,
  hazard_scoreboard_if.slave id,
  output logic               exe_wb_en,
  output logic               exe_mem_read,
  output logic [3:0]         exe_dest,
  output logic               mem_wb_en,
  output logic [3:0]         mem_dest,
  output logic [CNT_W-1:0]   stall_count
);

  logic m1e, m1m, m2e, m2m, raw;
  logic bubble, count_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    m1e = 1'b0;
    m1m = 1'b0;
    m2e = 1'b0;
    m2m = 1'b0;
    raw = 1'b0;
    m1e = exe_wb_en && (id.id_src1 == exe_dest);
    m1m = mem_wb_en && (id.id_src1 == mem_dest);
    m2e = id.id_two_src && exe_wb_en && (id.id_src2 == exe_dest);
    m2m = id.id_two_src && mem_wb_en && (id.id_src2 == mem_dest);
    // With forwarding, only a load still in EXE leaves data unavailable to ID.
    if (forward_en) raw = exe_mem_read && (m1e || m2e);
    else            raw = m1e || m1m || m2e || m2m;
  end

  assign id.hazard = raw && !id.id_ignore_hazard && !rst;
  assign bubble    = flush || id.hazard;
  // A flush already squashes ID, so a coincident hazard is not a stall of its own.
  assign count_en  = id.hazard && !flush && (stall_count != '1);

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_wb_en    <= 1'b0;
      exe_mem_read <= 1'b0;
      exe_dest     <= '0;
      mem_wb_en    <= 1'b0;
      mem_dest     <= '0;
      stall_count  <= '0;
    end else if (!freeze) begin
      mem_wb_en <= exe_wb_en;
      mem_dest  <= exe_dest;
      if (bubble) begin
        exe_wb_en    <= 1'b0;
        exe_mem_read <= 1'b0;
        exe_dest     <= '0;
      end else begin
        exe_wb_en    <= id.id_wb_en;
        exe_mem_read <= id.id_mem_read;
        exe_dest     <= id.id_dest;
      end
      if (count_en) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
